// File: rtl/spi_monarch_pkg.sv
// Shared types and divider constants for the mode-3, 16-bit SPI monarch.
package spi_monarch_pkg;

    typedef enum logic [1:0] {IDLE, FRONT, SHIFT} spi_state_t;

    // DIV_LOAD keeps div[4] (SCLK) high and leaves 9 clk to the first fall
    localparam logic [4:0] DIV_LOAD = 5'b10111;
    localparam logic [4:0] SMPL_PT  = 5'b01111;
    localparam logic [4:0] SHFT_PT  = 5'b11111;

endpackage

// File: rtl/spi_monarch_if.sv
// Command/response and SPI pin bundle between the inertial front end and the monarch.
// Handshake: wrt is a one-cycle strobe accepted only when the block is idle (cmd is
// captured on that edge); done stays high with rspns valid until the next accepted wrt.
interface spi_monarch_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rspns;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  wrt, cmd, MISO,
        output done, rspns, SS_n, SCLK, MOSI
    );

    modport slave (
        output wrt, cmd, MISO,
        input  done, rspns, SS_n, SCLK, MOSI
    );
endinterface

// File: rtl/spi_monarch.sv
// SPI mode-3 master: 16-bit transfers, SCLK = clk/32 taken from bit 4 of a free divider.
// Sampling happens on SCLK rise, shifting on SCLK fall; the 17th fall is suppressed.
module spi_monarch
    import spi_monarch_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    spi_monarch_if.master       bus,
    output spi_state_t          o_dbg_state
);

    spi_state_t  r_state;
    spi_state_t  w_next_state;
    logic [4:0]  r_div;
    logic [15:0] r_shft;
    logic [3:0]  r_bcnt;
    logic        r_miso_smpl;
    logic        r_ss_n;
    logic        r_done;

    logic        w_accept;
    logic        w_smpl;
    logic        w_shift;
    logic        w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_smpl       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.wrt) begin
                    w_accept     = 1'b1;
                    w_next_state = FRONT;
                end
            end
            FRONT: begin
                if (r_div == SHFT_PT) w_next_state = SHIFT;
            end
            SHIFT: begin
                if (r_div == SMPL_PT) w_smpl = 1'b1;
                if (r_div == SHFT_PT) begin
                    w_shift = 1'b1;
                    if (r_bcnt == 4'hF) begin
                        w_last       = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Divider wraps 31->0 naturally; reloading on the last shift keeps SCLK high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= DIV_LOAD;
            r_shft      <= 16'h0000;
            r_bcnt      <= 4'h0;
            r_miso_smpl <= 1'b0;
            r_ss_n      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            if (r_state == IDLE || w_last) r_div <= DIV_LOAD;
            else                           r_div <= r_div + 5'd1;

            if (w_accept)     r_shft <= bus.cmd;
            else if (w_shift) r_shft <= {r_shft[14:0], r_miso_smpl};

            if (w_accept)     r_bcnt <= 4'h0;
            else if (w_shift) r_bcnt <= r_bcnt + 4'h1;

            if (w_smpl) r_miso_smpl <= bus.MISO;

            if (w_accept)    r_ss_n <= 1'b0;
            else if (w_last) r_ss_n <= 1'b1;

            if (w_accept)    r_done <= 1'b0;
            else if (w_last) r_done <= 1'b1;
        end
    end

    assign bus.SCLK    = r_div[4];
    assign bus.MOSI    = r_shft[15];
    assign bus.rspns   = r_shft;
    assign bus.SS_n    = r_ss_n;
    assign bus.done    = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: doc/spi_monarch.md
# spi_monarch

SPI master (monarch) for the 16-bit, mode-3 transactions the inertial sensor serves. The nav/gyro front end presents a 16-bit command (R/Wn, 7-bit register address, 8-bit write data) with a one-cycle `wrt` strobe. The block drives `SS_n`, `SCLK` and `MOSI`, samples `MISO`, and returns the 16-bit word shifted in, flagged by `done`. It sits between the inertial-interface state machine and the board-level SPI pins.

## Interface

Parameters:
- None. The SCLK ratio is fixed at clk/32 by a 5-bit divider.

Ports:
- `clk`  in  1  System clock; the block's only clock.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `wrt`  in  1  One-cycle start strobe. Ignored unless the block is idle.
- `cmd`  in  16  Word to transmit, MSB first. Captured on the edge that accepts `wrt`.
- `done`  out  1  High when a transaction has completed. Stays high until the next accepted `wrt`.
- `rspns`  out  16  Word received from `MISO`, MSB first. Valid while `done` is high.
- `SS_n`  out  1  Active-low slave select, registered.
- `SCLK`  out  1  Serial clock; equals bit 4 of the divider. Idles high.
- `MOSI`  out  1  Equals bit 15 of the shift register.
- `MISO`  in  1  Serial data from the slave.

## Operation

- **Datapath**
  - 16-bit shift register `shft`; `rspns` = `shft`.
  - 5-bit divider `div`.
  - 4-bit bit counter `bcnt`.
  - 1-bit `miso_smpl`.
- **States:** IDLE, FRONT, SHIFT.
- **IDLE**
  - `div` is held at 5'b10111, so `SCLK`=1.
  - On `wrt`: `shft`←`cmd`, `bcnt`←0, `SS_n`←0, `done`←0, `div` starts counting, next state FRONT.
- **FRONT** (front porch)
  - `div` increments each clk.
  - When `div`==5'b11111: `div` wraps to 0, so `SCLK` falls. No shift occurs. Next state SHIFT.
- **SHIFT**
  - `div` increments every clk.
  - When `div`==5'b01111 (`SCLK` rises next edge): `miso_smpl`←`MISO`.
  - When `div`==5'b11111 and `bcnt`≠15: `shft`←{`shft`[14:0], `miso_smpl`} and `bcnt`++. `SCLK` falls.
  - When `div`==5'b11111 and `bcnt`==15:
    - perform the final shift;
    - `div`←5'b10111, so `SCLK` stays high (no 17th fall);
    - `SS_n`←1, `done`←1;
    - next state IDLE.
- **`wrt` while not IDLE:** ignored. `cmd` is not recaptured.
- **`wrt` while IDLE with `done`=1:** accepted normally; `done` clears on the accepting edge.
- **Reset values** (any time, including mid-transaction; effect is immediate):
  - state=IDLE, `SS_n`=1, `SCLK`=1 (`div`=5'b10111);
  - `shft`=0, so `MOSI`=0 and `rspns`=0;
  - `done`=0, `bcnt`=0, `miso_smpl`=0.
- **Pin activity per transaction:** exactly 16 `SCLK` falling edges and 16 rising edges.

## Timing

Edges are counted from E0, the clk edge that accepts `wrt`.

- **`SS_n`:** low from E0 to E521.
- **`SCLK`:**
  - first falling edge at E9;
  - rising edges at E(9+32k−16) for k=1..16;
  - falling edges at E(9+32k) for k=0..15.
- **`MISO` sampling:** bit k is sampled at E(9+32k−16), i.e. half a period after the preceding fall.
- **`MOSI` updates:** on `SCLK` falls; stable across each `SCLK` rise.
- **Completion:** `done`=1, `SS_n`=1 and final `rspns` are all visible after E521. Total latency is 521 clk.
- **Back-to-back:** the earliest next accepted `wrt` is at E522.

## Structure

- **Package `spi_monarch_pkg`:**
  - `typedef enum logic [1:0] {IDLE, FRONT, SHIFT} spi_state_t`;
  - `localparam DIV_LOAD = 5'b10111`;
  - `localparam SMPL_PT = 5'b01111`;
  - `localparam SHFT_PT = 5'b11111`.
- **Implementation:** a single module with no sub-modules; divider, counter and shift register are inline.

## Test plan

- **Reset:** hold `rst_n`=0 for 10 clk → `SS_n`=1, `SCLK`=1, `MOSI`=0, `done`=0, `rspns`=16'h0000. No `SCLK` edges until `wrt`.
- **Loopback:** tie `MISO` to `MOSI`; `wrt` with `cmd`=16'hA5C3 → `rspns`=16'hA5C3. `done` rises exactly 521 clk after the `wrt` edge. Exactly 16 rising and 16 falling `SCLK` edges are counted.
- **Read against the team's iNEMO SPI slave model:** `cmd`=16'h8F00 → `rspns`[7:0]=8'h6A.
- **Write then read:** write `cmd`=16'h0D02, then read `cmd`=16'h8D00 → `rspns`[7:0]=8'h02.
- **`wrt` mid-transaction:** pulse `wrt` with `cmd`=16'hFFFF at edge 200 of a transfer of 16'h1234 → the transfer is unaffected; loopback `rspns`=16'h1234; `done` still at edge 521.
- **Reset mid-transfer:** `rst_n` low at edge 300 → `SS_n`=1 and `SCLK`=1 immediately, `done`=0. A subsequent `wrt` of 16'h5A5A completes normally with loopback `rspns`=16'h5A5A.
